// File: rtl/alarm_clock_core.sv
// Alarm clock core: HH:MM:SS timekeeping, one alarm with snooze/dismiss/ring timeout,
// six registered 7-segment digit drivers and a pulsed buzzer output.
module alarm_clock_core #(
  parameter int TICK_DIV       = 50000000,
  parameter bit MODE_12H       = 1'b0,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_MAX_S     = 60,
  parameter int BUZZ_HALF      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_states,
  input  logic [1:0] btn_edit,
  output logic [6:0] led_seconds_units,
  output logic [6:0] led_seconds_tens,
  output logic [6:0] led_minutes_units,
  output logic [6:0] led_minutes_tens,
  output logic [6:0] led_hour_units,
  output logic [6:0] led_hour_tens,
  output logic       buzzer
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BUZZ_HALF + 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t         state;
  logic [2:0]     sw_s1, sw_s2;
  logic [1:0]     btn_s1, btn_s2, btn_d;
  logic [PW-1:0]  presc;
  logic [4:0]     hh, al_h, sn_h;
  logic [5:0]     mm, ss, al_m, sn_m;
  logic [7:0]     ring_cnt;
  logic [BW-1:0]  buzz_cnt;
  logic           buzz_ph;

  logic       set_time, set_alarm, alarm_en, tick, press_dis, press_snz;
  logic [1:0] btn_rise;
  logic [4:0] hh_n, tgt_h;
  logic [5:0] mm_n, ss_n, tgt_m;
  logic [6:0] snz_sum;
  logic       alarm_hit, snooze_hit;

  assign set_time  = sw_s2[0];
  assign set_alarm = sw_s2[1] & ~sw_s2[0];
  assign alarm_en  = sw_s2[2];
  assign btn_rise  = btn_s2 & ~btn_d;
  assign press_dis = btn_rise[1];
  assign press_snz = btn_rise[0] & ~btn_rise[1];
  assign tick      = !set_time && (presc == PW'(TICK_DIV - 1));
  assign snz_sum   = {1'b0, mm} + 7'(SNOOZE_MIN);

  // Time one second ahead, and the snooze target hh:mm relative to now.
  always_comb begin
    ss_n  = ss + 6'd1;
    mm_n  = mm;
    hh_n  = hh;
    tgt_m = snz_sum[5:0];
    tgt_h = hh;
    if (ss == 6'd59) begin
      ss_n = 6'd0;
      if (mm == 6'd59) begin
        mm_n = 6'd0;
        hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end else begin
        mm_n = mm + 6'd1;
      end
    end
    if (snz_sum >= 7'd60) begin
      tgt_m = 6'(snz_sum - 7'd60);
      tgt_h = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
    end
  end

  assign alarm_hit  = (hh_n == al_h) && (mm_n == al_m) && (ss_n == 6'd0);
  assign snooze_hit = (hh_n == sn_h) && (mm_n == sn_m) && (ss_n == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0; sw_s2 <= '0;
      btn_s1 <= '0; btn_s2 <= '0; btn_d <= '0;
      presc <= '0;
      hh <= '0; mm <= '0; ss <= '0;
      al_h <= '0; al_m <= '0; sn_h <= '0; sn_m <= '0;
      state <= IDLE;
      ring_cnt <= '0; buzz_cnt <= '0; buzz_ph <= 1'b0;
      buzzer <= 1'b0;
    end else begin
      sw_s1  <= sw_states;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_edit;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
      buzzer <= (state == RINGING) && buzz_ph;

      if (set_time) begin
        presc <= '0;
        ss    <= '0;
        if (state == IDLE) begin
          if (press_dis)      hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
          else if (press_snz) mm <= (mm == 6'd59) ? 6'd0 : mm + 6'd1;
        end
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          ss <= ss_n; mm <= mm_n; hh <= hh_n;
        end
        if (set_alarm && state == IDLE) begin
          if (press_dis)      al_h <= (al_h == 5'd23) ? 5'd0 : al_h + 5'd1;
          else if (press_snz) al_m <= (al_m == 6'd59) ? 6'd0 : al_m + 6'd1;
        end
      end

      case (state)
        IDLE: begin
          if (tick && alarm_en && alarm_hit) begin
            state <= RINGING; ring_cnt <= '0; buzz_cnt <= '0; buzz_ph <= 1'b1;
          end
        end
        RINGING: begin
          if (set_time || press_dis || !alarm_en) begin
            state <= IDLE;
          end else if (press_snz) begin
            state <= SNOOZED; sn_h <= tgt_h; sn_m <= tgt_m;
          end else begin
            if (buzz_cnt == BW'(BUZZ_HALF - 1)) begin
              buzz_cnt <= '0; buzz_ph <= ~buzz_ph;
            end else begin
              buzz_cnt <= buzz_cnt + 1'b1;
            end
            // The entry tick is not counted; RING_MAX_S further ticks end the ring.
            if (tick) begin
              if (ring_cnt == 8'(RING_MAX_S - 1)) state <= IDLE;
              else ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
        SNOOZED: begin
          if (set_time || press_dis || !alarm_en) begin
            state <= IDLE;
          end else if (tick && snooze_hit) begin
            state <= RINGING; ring_cnt <= '0; buzz_cnt <= '0; buzz_ph <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
      4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
      4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h00;
    endcase
    if (blank) s = 7'h00;
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  logic [4:0] d_h, h_disp;
  logic [5:0] d_m, d_s;

  always_comb begin
    d_h = hh; d_m = mm; d_s = ss;
    if (set_alarm) begin
      d_h = al_h; d_m = al_m; d_s = 6'd0;
    end
    h_disp = d_h;
    if (MODE_12H) begin
      if (d_h == 5'd0)       h_disp = 5'd12;
      else if (d_h > 5'd12)  h_disp = d_h - 5'd12;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_seconds_units <= seg7(4'd0, 1'b0);
      led_seconds_tens  <= seg7(4'd0, 1'b0);
      led_minutes_units <= seg7(4'd0, 1'b0);
      led_minutes_tens  <= seg7(4'd0, 1'b0);
      led_hour_units    <= seg7(MODE_12H ? 4'd2 : 4'd0, 1'b0);
      led_hour_tens     <= seg7(4'd0, MODE_12H);
    end else begin
      led_seconds_units <= seg7(units(d_s), 1'b0);
      led_seconds_tens  <= seg7(tens(d_s), 1'b0);
      led_minutes_units <= seg7(units(d_m), 1'b0);
      led_minutes_tens  <= seg7(tens(d_m), 1'b0);
      led_hour_units    <= seg7(units({1'b0, h_disp}), 1'b0);
      led_hour_tens     <= seg7(tens({1'b0, h_disp}),
                                MODE_12H && (tens({1'b0, h_disp}) == 4'd0));
    end
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core: a 24h active-low instance and a 12h
// active-high instance share one stimulus stream.
module tb_alarm_clock_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] sw;
  logic [1:0] btn;
  logic [6:0] a_su, a_st, a_mu, a_mt, a_hu, a_ht;
  logic [6:0] b_su, b_st, b_mu, b_mt, b_hu, b_ht;
  logic       a_bz, b_bz;
  logic [41:0] a_disp, b_disp, exp_d;
  int checks = 0;
  int errors = 0;

  assign a_disp = {a_ht, a_hu, a_mt, a_mu, a_st, a_su};
  assign b_disp = {b_ht, b_hu, b_mt, b_mu, b_st, b_su};

  alarm_clock_core #(.TICK_DIV(4), .MODE_12H(1'b0), .SNOOZE_MIN(1), .RING_MAX_S(3),
                     .BUZZ_HALF(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .sw_states(sw), .btn_edit(btn),
    .led_seconds_units(a_su), .led_seconds_tens(a_st),
    .led_minutes_units(a_mu), .led_minutes_tens(a_mt),
    .led_hour_units(a_hu), .led_hour_tens(a_ht), .buzzer(a_bz));

  alarm_clock_core #(.TICK_DIV(4), .MODE_12H(1'b1), .SNOOZE_MIN(1), .RING_MAX_S(3),
                     .BUZZ_HALF(2), .SEG_ACTIVE_LOW(1'b0)) dut12 (
    .clk(clk), .reset(reset), .sw_states(sw), .btn_edit(btn),
    .led_seconds_units(b_su), .led_seconds_tens(b_st),
    .led_minutes_units(b_mu), .led_minutes_tens(b_mt),
    .led_hour_units(b_hu), .led_hour_tens(b_ht), .buzzer(b_bz));

  // Active-high g..a patterns; any digit outside 0..9 means blank.
  function automatic logic [6:0] seg_hi(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int h1, input int h0, input int m1,
                                       input int m0, input int s1, input int s0,
                                       input bit low);
    logic [41:0] v;
    v = {seg_hi(h1), seg_hi(h0), seg_hi(m1), seg_hi(m0), seg_hi(s1), seg_hi(s0)};
    return low ? ~v : v;
  endfunction

  task automatic press(input int which);
    btn[which] = 1'b1;
    repeat (2) @(negedge clk);
    btn = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = 3'b000; btn = 2'b00;
    repeat (2) @(negedge clk);
    exp_d = disp(0, 0, 0, 0, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL reset_disp24 got %h want %h", a_disp, exp_d); end
    exp_d = disp(10, 2, 0, 0, 0, 0, 1'b0);
    checks++;
    if (b_disp !== exp_d) begin errors++; $display("FAIL reset_disp12 got %h want %h", b_disp, exp_d); end
    checks++;
    if (a_bz !== 1'b0) begin errors++; $display("FAIL reset_buzzer got %b want 0", a_bz); end
    reset = 1'b0;
    @(negedge clk);
    exp_d = disp(1, 2, 0, 0, 0, 0, 1'b0);
    checks++;
    if (b_disp !== exp_d) begin errors++; $display("FAIL disp12_midnight got %h want %h", b_disp, exp_d); end
  endtask

  task automatic test_set_alarm();
    sw = 3'b010;
    repeat (4) @(negedge clk);
    press(0);
    repeat (2) @(negedge clk);
    exp_d = disp(0, 0, 0, 1, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL alarm_edit got %h want %h", a_disp, exp_d); end
    sw = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_set_time();
    sw = 3'b001;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 25; i++) press(1);
    for (int i = 0; i < 61; i++) press(0);
    exp_d = disp(0, 1, 0, 1, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL set_time_wrap got %h want %h", a_disp, exp_d); end
    repeat (40) @(negedge clk);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL seconds_frozen got %h want %h", a_disp, exp_d); end
  endtask

  task automatic test_simultaneous();
    btn = 2'b11;
    repeat (2) @(negedge clk);
    btn = 2'b00;
    repeat (4) @(negedge clk);
    exp_d = disp(0, 2, 0, 1, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL both_buttons got %h want %h", a_disp, exp_d); end
    for (int i = 0; i < 21; i++) press(1);
    for (int i = 0; i < 58; i++) press(0);
    exp_d = disp(2, 3, 5, 9, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL set_2359 got %h want %h", a_disp, exp_d); end
  endtask

  task automatic test_wrap_and_ring();
    int n;
    sw = 3'b100;
    repeat (240) @(posedge clk);
    @(negedge clk);
    exp_d = disp(2, 3, 5, 9, 5, 9, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL pre_wrap got %h want %h", a_disp, exp_d); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    exp_d = disp(0, 0, 0, 0, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL day_wrap got %h want %h", a_disp, exp_d); end
    checks++;
    if (a_hu !== 7'h40) begin errors++; $display("FAIL hour_units_zero got %h want 40", a_hu); end

    n = 0;
    while (a_bz !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL ring_timeout got no buzz want buzz"); end
    exp_d = disp(0, 0, 0, 1, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL ring_time got %h want %h", a_disp, exp_d); end
    @(negedge clk);
    checks++;
    if (a_bz !== 1'b1) begin errors++; $display("FAIL buzz_c2 got %b want 1", a_bz); end
    @(negedge clk);
    checks++;
    if (a_bz !== 1'b0) begin errors++; $display("FAIL buzz_c3 got %b want 0", a_bz); end
    @(negedge clk);
    checks++;
    if (a_bz !== 1'b0) begin errors++; $display("FAIL buzz_c4 got %b want 0", a_bz); end
  endtask

  task automatic test_snooze_dismiss();
    int n, highs;
    press(0);
    checks++;
    if (a_bz !== 1'b0) begin errors++; $display("FAIL snooze_silence got %b want 0", a_bz); end
    highs = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (a_bz === 1'b1) highs++; end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL snooze_quiet got %0d highs want 0", highs); end
    n = 0;
    while (a_bz !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL rering_timeout got no buzz want buzz"); end
    exp_d = disp(0, 0, 0, 2, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL rering_time got %h want %h", a_disp, exp_d); end
    press(1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (a_bz === 1'b1) highs++; end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL dismiss got %0d highs want 0", highs); end
  endtask

  task automatic test_ring_timeout();
    int n, highs;
    sw = 3'b110;
    repeat (4) @(negedge clk);
    press(0);
    press(0);
    repeat (2) @(negedge clk);
    exp_d = disp(0, 0, 0, 3, 0, 0, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL alarm_0003 got %h want %h", a_disp, exp_d); end
    sw = 3'b100;
    n = 0;
    while (a_bz !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL ring3_timeout got no buzz want buzz"); end
    repeat (8) @(negedge clk);
    checks++;
    if (a_bz !== 1'b1) begin errors++; $display("FAIL ring_still_on got %b want 1", a_bz); end
    repeat (4) @(negedge clk);
    checks++;
    if (a_bz !== 1'b0) begin errors++; $display("FAIL ring_auto_off got %b want 0", a_bz); end
    highs = 0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (a_bz === 1'b1) highs++; end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL no_rering got %0d highs want 0", highs); end
  endtask

  task automatic test_12h();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sw = 3'b001;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 13; i++) press(1);
    for (int i = 0; i < 5; i++) press(0);
    exp_d = disp(10, 1, 0, 5, 0, 0, 1'b0);
    checks++;
    if (b_disp !== exp_d) begin errors++; $display("FAIL disp12_1305 got %h want %h", b_disp, exp_d); end
    sw = 3'b000;
    repeat (40) @(posedge clk);
    @(negedge clk);
    exp_d = disp(1, 3, 0, 5, 0, 9, 1'b1);
    checks++;
    if (a_disp !== exp_d) begin errors++; $display("FAIL disp24_130509 got %h want %h", a_disp, exp_d); end
    exp_d = disp(10, 1, 0, 5, 0, 9, 1'b0);
    checks++;
    if (b_disp !== exp_d) begin errors++; $display("FAIL disp12_130509 got %h want %h", b_disp, exp_d); end
  endtask

  initial begin
    test_reset();
    test_set_alarm();
    test_set_time();
    test_simultaneous();
    test_wrap_and_ring();
    test_snooze_dismiss();
    test_ring_timeout();
    test_12h();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
